// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } div_state_t;

    localparam int DIV_CYCLES = 32;

    localparam logic [63:0] DIV_RESULT_ZERO = 64'h0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FREE    | idle, waiting for a start request
// BY_ZERO | divisor was zero; two-cycle slot that produces a zero result
// ON      | iterating; the final ON cycle applies the sign fix-up
// END     | result valid, held until i_start drops
module div_unit #(
    parameter int N_DATA     = 32,
    parameter int DIV_CYCLES = div_pkg::DIV_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic [N_DATA-1:0]     i_dividend,
    input  logic [N_DATA-1:0]     i_divisor,
    input  logic                  i_annul,
    output logic [2*N_DATA-1:0]   o_result,
    output logic                  o_ready,
    output logic                  o_busy
);
    import div_pkg::*;

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    div_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [N_DATA-1:0]   rem_q;
    logic [N_DATA-1:0]   quo_q;
    logic [N_DATA-1:0]   dvsr_q;
    logic                neg_q;
    logic                neg_r;

    logic [N_DATA:0]     shifted;
    logic [N_DATA:0]     trial;
    logic [N_DATA-1:0]   a_mag;
    logic [N_DATA-1:0]   b_mag;
    logic [N_DATA-1:0]   quo_fix;
    logic [N_DATA-1:0]   rem_fix;

    // Datapath: magnitudes at latch time, trial subtraction, final sign fix-up.
    // The remainder stays below the divisor, so the 33-bit trial's MSB is a
    // reliable sign even when the shifted remainder itself exceeds 32 bits.
    always_comb begin
        shifted = {rem_q, quo_q[N_DATA-1]};
        trial   = shifted - {1'b0, dvsr_q};
        a_mag   = (i_signed && i_dividend[N_DATA-1]) ? (N_DATA'(0) - i_dividend) : i_dividend;
        b_mag   = (i_signed && i_divisor[N_DATA-1])  ? (N_DATA'(0) - i_divisor)  : i_divisor;
        quo_fix = neg_q ? (N_DATA'(0) - quo_q) : quo_q;
        rem_fix = neg_r ? (N_DATA'(0) - rem_q) : rem_q;
    end

    // Control FSM with registered outputs; reset and annul never expose partial results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            o_result <= DIV_RESULT_ZERO;
            o_ready  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (i_start && !i_annul) begin
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        if (i_divisor != '0) begin
                            rem_q  <= '0;
                            quo_q  <= a_mag;
                            dvsr_q <= b_mag;
                            neg_q  <= i_signed && (i_dividend[N_DATA-1] ^ i_divisor[N_DATA-1]);
                            neg_r  <= i_signed && i_dividend[N_DATA-1];
                            state  <= ON;
                        end else begin
                            state  <= BY_ZERO;
                        end
                    end
                end
                BY_ZERO: begin
                    // Held for two cycles so a zero divisor has a fixed latency.
                    o_result <= DIV_RESULT_ZERO;
                    if (i_annul) begin
                        state  <= FREE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        state   <= END;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (i_annul) begin
                        state    <= FREE;
                        cnt      <= '0;
                        o_result <= DIV_RESULT_ZERO;
                        o_busy   <= 1'b0;
                    end else if (cnt == CNT_W'(DIV_CYCLES)) begin
                        o_result <= {rem_fix, quo_fix};
                        state    <= END;
                        o_busy   <= 1'b0;
                        o_ready  <= 1'b1;
                    end else begin
                        if (!trial[N_DATA]) begin
                            rem_q <= trial[N_DATA-1:0];
                        end else begin
                            rem_q <= shifted[N_DATA-1:0];
                        end
                        quo_q <= {quo_q[N_DATA-2:0], ~trial[N_DATA]};
                        cnt   <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (!i_start) begin
                        state   <= FREE;
                        o_ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= FREE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
